// File: rtl/food_logic.sv
// Food responder for the snake game: places food at a pseudo-random cell, plots it once,
// checks the snake head against it on each food_en strobe and owns the snake length.
module food_logic #(
    parameter logic [8:0]  X_MAX       = 9'd160,
    parameter logic [7:0]  Y_MAX       = 8'd120,
    parameter logic [10:0] LEN_INIT    = 11'd4,
    parameter logic [10:0] LEN_MAX     = 11'd1023,
    parameter logic [2:0]  FOOD_COLOUR = 3'b100,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        food_en,
    input  logic [7:0]  head_x,
    input  logic [6:0]  head_y,
    output logic [10:0] length,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        plotEn,
    output logic [2:0]  colour_out,
    output logic        ate,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_PICK  = 2'd0,
        S_DRAW  = 2'd1,
        S_IDLE  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    function automatic logic [10:0] len_inc(input logic [10:0] cur);
        return (cur == LEN_MAX) ? cur : cur + 11'd1;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lfsr_q;
    logic [7:0]  food_x_q, food_x_d;
    logic [6:0]  food_y_q, food_y_d;
    logic [10:0] length_q, length_d;
    logic        pending_q, pending_d;
    logic        plot_q, plot_d;
    logic [2:0]  colour_q, colour_d;
    logic        ate_q, ate_d;
    logic        busy_q, busy_d;

    logic [7:0]  cand_x_s;
    logic [6:0]  cand_y_s;
    logic        cand_ok_s;
    logic        hit_s;

    assign cand_x_s  = lfsr_q[7:0];
    assign cand_y_s  = lfsr_q[14:8];
    assign cand_ok_s = ({1'b0, cand_x_s} < X_MAX) && ({1'b0, cand_y_s} < Y_MAX) &&
                       !((cand_x_s == head_x) && (cand_y_s == head_y));
    assign hit_s     = (head_x == food_x_q) && (head_y == food_y_q);

    // State, food, length and registered output flops; reset abandons any plot in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_PICK;
            lfsr_q    <= LFSR_SEED;
            food_x_q  <= 8'd0;
            food_y_q  <= 7'd0;
            length_q  <= LEN_INIT;
            pending_q <= 1'b0;
            plot_q    <= 1'b0;
            colour_q  <= 3'b000;
            ate_q     <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_next(lfsr_q);
            food_x_q  <= food_x_d;
            food_y_q  <= food_y_d;
            length_q  <= length_d;
            pending_q <= pending_d;
            plot_q    <= plot_d;
            colour_q  <= colour_d;
            ate_q     <= ate_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; strobes arriving outside S_IDLE collapse into one pending check.
    always_comb begin
        state_d  = state_q;
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        length_d = length_q;
        if (food_en && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
        case (state_q)
            S_PICK: begin
                if (cand_ok_s) begin
                    food_x_d = cand_x_s;
                    food_y_d = cand_y_s;
                    state_d  = S_DRAW;
                end else begin
                    state_d = S_PICK;
                end
            end
            S_DRAW: state_d = S_IDLE;
            S_IDLE: begin
                if (food_en || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (hit_s) begin
                    length_d = len_inc(length_q);
                    state_d  = S_PICK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_PICK;
        endcase
    end

    // Output decode; busy also spans the plot strobe so the mux keeps this block selected.
    always_comb begin
        plot_d = (state_q == S_DRAW);
        if (plot_d) begin
            colour_d = FOOD_COLOUR;
        end else begin
            colour_d = 3'b000;
        end
        ate_d  = (state_q == S_CHECK) && hit_s;
        busy_d = (state_d == S_PICK) || (state_d == S_DRAW) || (state_q == S_DRAW);
    end

    assign length     = length_q;
    assign x          = food_x_q;
    assign y          = food_y_q;
    assign plotEn     = plot_q;
    assign colour_out = colour_q;
    assign ate        = ate_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_food_logic.sv
// Bench for food_logic: a cycle-level behavioural reference model is compared with the
// DUT on every falling edge, alongside directed scenarios with literal expectations.
module tb_food_logic;

    localparam int P_PICK  = 0;
    localparam int P_DRAW  = 1;
    localparam int P_IDLE  = 2;
    localparam int P_CHECK = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        food_en = 1'b0;
    logic [7:0]  head_x = 8'd255;
    logic [6:0]  head_y = 7'd127;
    logic [10:0] length;
    logic [7:0]  x;
    logic [6:0]  y;
    logic        plotEn;
    logic [2:0]  colour_out;
    logic        ate;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int          m_mode, m_len, m_fx, m_fy;
    int unsigned m_lfsr;
    bit          m_pend, m_valid;
    bit          e_plot, e_ate, e_busy;

    food_logic dut (
        .clk        (clk),
        .rst        (rst),
        .food_en    (food_en),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .x          (x),
        .y          (y),
        .plotEn     (plotEn),
        .colour_out (colour_out),
        .ate        (ate),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the reference: the spec's rules applied to the values seen at this edge.
    task automatic model_step();
        int old_mode, cx, cy;
        int unsigned fb;
        if (!rst) begin
            m_mode = P_PICK; m_len = 4; m_fx = 0; m_fy = 0;
            m_lfsr = 32'hACE1; m_pend = 1'b0;
            e_plot = 1'b0; e_ate = 1'b0; e_busy = 1'b1;
            m_valid = 1'b1;
        end else begin
            old_mode = m_mode;
            cx = int'(m_lfsr % 256);
            cy = int'((m_lfsr / 256) % 128);
            e_plot = 1'b0;
            e_ate  = 1'b0;
            if (old_mode == P_PICK) begin
                if (cx < 160 && cy < 120 && !(cx == int'(head_x) && cy == int'(head_y))) begin
                    m_fx = cx; m_fy = cy; m_mode = P_DRAW;
                end
            end else if (old_mode == P_DRAW) begin
                e_plot = 1'b1; m_mode = P_IDLE;
            end else if (old_mode == P_IDLE) begin
                if (food_en || m_pend) begin
                    m_pend = 1'b0; m_mode = P_CHECK;
                end
            end else begin
                if (int'(head_x) == m_fx && int'(head_y) == m_fy) begin
                    e_ate = 1'b1;
                    m_len = (m_len + 1 > 1023) ? 1023 : m_len + 1;
                    m_mode = P_PICK;
                end else begin
                    m_mode = P_IDLE;
                end
            end
            if (food_en && old_mode != P_IDLE) m_pend = 1'b1;
            e_busy = (m_mode == P_PICK) || (m_mode == P_DRAW) || (old_mode == P_DRAW);
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 32'd1;
            m_lfsr = ((m_lfsr << 1) | fb) & 32'hFFFF;
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        if (m_valid) begin
            check("length", int'(length), m_len);
            check("x", int'(x), m_fx);
            check("y", int'(y), m_fy);
            check("plotEn", int'(plotEn), int'(e_plot));
            check("colour", int'(colour_out), e_plot ? 4 : 0);
            check("ate", int'(ate), int'(e_ate));
            check("busy", int'(busy), int'(e_busy));
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 80 && m_mode != P_IDLE; i++) @(negedge clk);
        check("idle_reached", int'(m_mode == P_IDLE), 1);
    endtask

    task automatic wait_plot();
        int i;
        for (i = 0; i < 300 && plotEn !== 1'b1; i++) @(negedge clk);
        check("plot_reached", int'(plotEn === 1'b1), 1);
    endtask

    // Put the head on the modelled food and strobe food_en; returns where ate is visible.
    task automatic do_hit();
        wait_idle();
        head_x = 8'(m_fx);
        head_y = 7'(m_fy);
        food_en = 1'b1;
        @(negedge clk);
        food_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int old_x, old_y, cnt_ate, cnt_plot, n;

        // Reset held for three edges
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_length", int'(length), 4);
        check("rst_plotEn", int'(plotEn), 0);
        check("rst_ate", int'(ate), 0);
        check("rst_busy", int'(busy), 1);

        // First plot after reset
        wait_plot();
        check("first_colour", int'(colour_out), 4);
        check("first_x_range", int'(x < 8'd160), 1);
        check("first_y_range", int'(y < 7'd120), 1);
        @(negedge clk);
        check("busy_after_plot", int'(busy), 0);

        // Hit: ate one cycle after the check, length 4->5, new food elsewhere
        old_x = m_fx; old_y = m_fy;
        do_hit();
        check("hit_ate", int'(ate), 1);
        check("hit_length", int'(length), 5);
        wait_plot();
        check("new_x_range", int'(x < 8'd160), 1);
        check("new_y_range", int'(y < 7'd120), 1);
        check("new_pos_differs", int'(int'(x) != old_x || int'(y) != old_y), 1);
        @(negedge clk);

        // Miss: nothing happens for 20 cycles
        wait_idle();
        head_x = (m_fx == 0) ? 8'd1 : 8'd0;
        head_y = 7'(m_fy);
        food_en = 1'b1;
        @(negedge clk);
        food_en = 1'b0;
        cnt_ate = 0; cnt_plot = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ate) cnt_ate++;
            if (plotEn) cnt_plot++;
        end
        check("miss_ate_count", cnt_ate, 0);
        check("miss_plot_count", cnt_plot, 0);
        check("miss_length", int'(length), 5);

        // Two strobes while busy collapse into one check after the draw
        do_hit();
        check("pend_hit_length", int'(length), 6);
        check("pend_busy1", int'(busy), 1);
        food_en = 1'b1;
        @(negedge clk);
        check("pend_busy2", int'(busy), 1);
        @(negedge clk);
        food_en = 1'b0;
        wait_plot();
        head_x = 8'(m_fx);
        head_y = 7'(m_fy);
        cnt_ate = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ate) cnt_ate++;
        end
        check("pend_ate_count", cnt_ate, 1);
        check("pend_length", int'(length), 7);

        // Randomised traffic: strobes and heads, often on the food
        for (int i = 0; i < 3000; i++) begin
            food_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin
                head_x = 8'(m_fx);
                head_y = 7'(m_fy);
            end else begin
                head_x = 8'($urandom_range(0, 255));
                head_y = 7'($urandom_range(0, 127));
            end
            @(negedge clk);
        end
        food_en = 1'b0;
        repeat (10) @(negedge clk);

        // Drive the length to saturation, then one more hit
        n = 0;
        while (m_len < 1023 && n < 1100) begin
            do_hit();
            n++;
        end
        check("sat_reached", int'(length), 1023);
        do_hit();
        check("sat_ate", int'(ate), 1);
        check("sat_length", int'(length), 1023);

        // Reset while picking
        check("mid_pick_busy", int'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_pick_rst_length", int'(length), 4);
        check("mid_pick_rst_plotEn", int'(plotEn), 0);
        rst = 1'b1;
        wait_plot();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
